// File: rtl/l1_trig_pkg.sv
// Shared types for the L1 trigger event builder: FSM states, record layout and packing helper.
package l1_trig_pkg;

   typedef enum logic [1:0] {StIdle, StGather, StEmit, StHoldoff} state_e;

   localparam int unsigned REC_W     = 128;
   localparam int unsigned BEAMS_LSB = 0;
   localparam int unsigned BEAMS_W   = 32;
   localparam int unsigned EVNUM_LSB = 32;
   localparam int unsigned EVNUM_W   = 32;
   localparam int unsigned TS_LSB    = 64;
   localparam int unsigned TS_W      = 48;

   typedef struct packed {
      logic [REC_W-TS_LSB-TS_W-1:0] rsvd;
      logic [TS_W-1:0]              ts;
      logic [EVNUM_W-1:0]           evnum;
      logic [BEAMS_W-1:0]           beams;
   } evt_rec_t;

   // Unused bits are forced to zero so downstream can rely on them.
   function automatic evt_rec_t pack_rec(logic [BEAMS_W-1:0] beams,
                                         logic [EVNUM_W-1:0] evnum,
                                         logic [TS_W-1:0]    ts);
      logic [REC_W-1:0] r;
      r = '0;
      r[BEAMS_LSB +: BEAMS_W] = beams;
      r[EVNUM_LSB +: EVNUM_W] = evnum;
      r[TS_LSB +: TS_W]       = ts;
      return evt_rec_t'(r);
   endfunction

endpackage

// File: rtl/l1_trig_evt_fifo.sv
// First-word-fall-through event FIFO; DEPTH must be a power of two (pointers wrap naturally).
module l1_trig_evt_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop) count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/l1_trigger_event_builder.sv
// Coincidence-window event builder for L1 beam triggers with FWFT record FIFO.
// Optional per-beam raw-trigger scalers are enabled by defining L1_TRIG_SCALERS_EN.
module l1_trigger_event_builder
   import l1_trig_pkg::*;
#(
   parameter int unsigned NBEAMS     = 2,
   parameter int unsigned WINDOW     = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 aclk,
   input  logic                 reset_i,
   input  logic [NBEAMS-1:0]    trig_i,
   input  logic [NBEAMS-1:0]    beam_mask_i,
   input  logic [15:0]          holdoff_i,
   output logic [REC_W-1:0]     evt_tdata,
   output logic                 evt_tvalid,
   input  logic                 evt_tready,
   output logic [31:0]          event_count_o,
   output logic                 overflow_o
`ifdef L1_TRIG_SCALERS_EN
   ,
   input  logic                 scaler_clr_i,
   output logic [NBEAMS*16-1:0] scaler_o
`endif
);

   // Last GATHER count value; unused when WINDOW=1 since GATHER is skipped.
   localparam logic [3:0] WIN_LAST = (WINDOW > 1) ? 4'(WINDOW - 2) : 4'd0;

   state_e              state_q, state_d;
   logic [NBEAMS-1:0]   beams_q, beams_d, trig_en;
   logic [TS_W-1:0]     tstamp_q, ts_q, ts_d;
   logic [3:0]          win_q, win_d;
   logic [15:0]         hold_q, hold_d;
   logic [31:0]         evt_cnt_q;
   logic                ovf_q;
   logic                emit, push_ok, fifo_pop, fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   evt_rec_t            rec;

   assign trig_en = trig_i & ~beam_mask_i;

   always_comb begin
      state_d = state_q;
      beams_d = beams_q;
      ts_d    = ts_q;
      win_d   = win_q;
      hold_d  = hold_q;
      emit    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|trig_en) begin
               beams_d = trig_en;
               ts_d    = tstamp_q;
               win_d   = '0;
               state_d = (WINDOW == 1) ? StEmit : StGather;
            end
         end
         StGather: begin
            beams_d = beams_q | trig_en;
            win_d   = win_q + 4'd1;
            if (win_q == WIN_LAST) state_d = StEmit;
         end
         StEmit: begin
            emit = 1'b1;
            if (holdoff_i == 16'd0) begin
               state_d = StIdle;
            end else begin
               hold_d  = holdoff_i - 16'd1;
               state_d = StHoldoff;
            end
         end
         StHoldoff: begin
            if (hold_q == 16'd0) state_d = StIdle;
            else hold_d = hold_q - 16'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   assign fifo_pop = evt_tvalid & evt_tready;
   assign push_ok  = emit & (~fifo_full | fifo_pop);
   assign rec      = pack_rec(BEAMS_W'(beams_q), evt_cnt_q, ts_q);

   always_ff @(posedge aclk or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         beams_q   <= '0;
         ts_q      <= '0;
         tstamp_q  <= '0;
         win_q     <= '0;
         hold_q    <= '0;
         evt_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         beams_q  <= beams_d;
         ts_q     <= ts_d;
         tstamp_q <= tstamp_q + TS_W'(1);
         win_q    <= win_d;
         hold_q   <= hold_d;
         if (push_ok) evt_cnt_q <= evt_cnt_q + 32'd1;
         if (emit && !push_ok) ovf_q <= 1'b1;
      end
   end

   l1_trig_evt_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (aclk),
      .rst_i   (reset_i),
      .push_i  (push_ok),
      .wdata_i (rec),
      .pop_i   (fifo_pop),
      .rdata_o (evt_tdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign evt_tvalid    = ~fifo_empty;
   assign event_count_o = evt_cnt_q;
   assign overflow_o    = ovf_q;

   a_fifo_count_bound: assert property (@(posedge aclk) disable iff (reset_i)
      fifo_count <= ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));

`ifdef L1_TRIG_SCALERS_EN
   for (genvar b = 0; b < NBEAMS; b++) begin : g_scaler
      logic [15:0] sc_q;
      // Raw trigger count, independent of mask and FSM; clear wins over increment.
      always_ff @(posedge aclk or posedge reset_i) begin
         if (reset_i) sc_q <= '0;
         else if (scaler_clr_i) sc_q <= '0;
         else if (trig_i[b] && (sc_q != 16'hFFFF)) sc_q <= sc_q + 16'd1;
      end
      assign scaler_o[b*16 +: 16] = sc_q;
   end
`endif

endmodule

// File: tb/tb_l1_trigger_event_builder.sv
// Scoreboard bench for l1_trigger_event_builder: directed stimulus pushes expected records,
// a negedge monitor pops and compares on every handshake. Define L1_TRIG_SCALERS_EN for scalers.
module tb_l1_trigger_event_builder;

   localparam int unsigned NBEAMS     = 2;
   localparam int unsigned WINDOW     = 4;
   localparam int unsigned FIFO_DEPTH = 4;

   logic          aclk = 1'b0;
   logic          reset_i;
   logic [1:0]    trig_i, beam_mask_i;
   logic [15:0]   holdoff_i;
   logic [127:0]  evt_tdata;
   logic          evt_tvalid, evt_tready;
   logic [31:0]   event_count_o;
   logic          overflow_o;
`ifdef L1_TRIG_SCALERS_EN
   logic          scaler_clr_i;
   logic [31:0]   scaler_o;
`endif

   int            n_vec = 0;
   int            n_bad = 0;
   logic [127:0]  exp_q[$];
   logic [47:0]   cyc;
   logic          hold_v;
   logic [127:0]  hold_data;

   l1_trigger_event_builder #(
      .NBEAMS     (NBEAMS),
      .WINDOW     (WINDOW),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .aclk          (aclk),
      .reset_i       (reset_i),
      .trig_i        (trig_i),
      .beam_mask_i   (beam_mask_i),
      .holdoff_i     (holdoff_i),
      .evt_tdata     (evt_tdata),
      .evt_tvalid    (evt_tvalid),
      .evt_tready    (evt_tready),
      .event_count_o (event_count_o),
      .overflow_o    (overflow_o)
`ifdef L1_TRIG_SCALERS_EN
      ,
      .scaler_clr_i  (scaler_clr_i),
      .scaler_o      (scaler_o)
`endif
   );

   always #5 aclk = ~aclk;

   // Reference time base: cycles since reset release.
   always @(posedge aclk or posedge reset_i) begin
      if (reset_i) cyc <= '0;
      else cyc <= cyc + 48'd1;
   end

   function automatic logic [127:0] mk_rec(logic [1:0] beams, logic [31:0] evn, logic [47:0] ts);
      logic [127:0] r;
      r = '0;
      r[1:0]    = beams;
      r[63:32]  = evn;
      r[111:64] = ts;
      return r;
   endfunction

   task automatic check(string name, logic [127:0] got, logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: compare on handshake, and check tdata holds while stalled.
   always @(negedge aclk) begin
      if (reset_i) begin
         hold_v <= 1'b0;
      end else if (evt_tvalid) begin
         if (hold_v) check("tdata_stable", evt_tdata, hold_data);
         if (evt_tready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_record: got %h expected none", evt_tdata);
            end else begin
               check("record", evt_tdata, exp_q.pop_front());
            end
            hold_v <= 1'b0;
         end else begin
            hold_v    <= 1'b1;
            hold_data <= evt_tdata;
         end
      end else begin
         hold_v <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      exp_q.delete();
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   task automatic pulse(logic [1:0] t);
      trig_i = t;
      tick();
      trig_i = 2'b00;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] c;
      logic [1:0]  b;
      reset_i     = 1'b1;
      trig_i      = 2'b00;
      beam_mask_i = 2'b00;
      holdoff_i   = 16'd0;
      evt_tready  = 1'b1;
`ifdef L1_TRIG_SCALERS_EN
      scaler_clr_i = 1'b0;
`endif
      tick(); tick(); tick();
      check("rst_tvalid", evt_tvalid, 0);
      check("rst_count", event_count_o, 0);
      check("rst_overflow", overflow_o, 0);
      reset_i = 1'b0;
      tick();

      // Two beams merged inside one window, latency WINDOW+1.
      c = cyc;
      exp_q.push_back(mk_rec(2'b11, 0, c));
      trig_i = 2'b01; tick();
      trig_i = 2'b00; tick();
      trig_i = 2'b10; tick();
      trig_i = 2'b00; tick();
      check("lat_c4_tvalid", evt_tvalid, 0);
      tick();
      check("lat_c5_tvalid", evt_tvalid, 1);
      tick();
      check("win_count", event_count_o, 1);

      // Holdoff of 10 swallows the trigger at +8 but not the one at +20.
      do_reset();
      holdoff_i = 16'd10;
      tick();
      c = cyc;
      exp_q.push_back(mk_rec(2'b01, 0, c));
      exp_q.push_back(mk_rec(2'b10, 1, c + 48'd20));
      for (int i = 0; i < 30; i++) begin
         trig_i = (i == 0) ? 2'b01 : ((i == 8 || i == 20) ? 2'b10 : 2'b00);
         tick();
      end
      trig_i = 2'b00;
      drain();
      check("hold_count", event_count_o, 2);
      check("hold_overflow", overflow_o, 0);

      // Masked beam never starts an event; unmasked beam does.
      do_reset();
      holdoff_i   = 16'd0;
      beam_mask_i = 2'b01;
      for (int i = 0; i < 12; i++) begin
         trig_i = (i % 3 == 0) ? 2'b01 : 2'b00;
         tick();
      end
      trig_i = 2'b00;
      check("mask_tvalid", evt_tvalid, 0);
      check("mask_count", event_count_o, 0);
      c = cyc;
      exp_q.push_back(mk_rec(2'b10, 0, c));
      pulse(2'b10);
      repeat (6) tick();
      drain();
      check("mask_count_after", event_count_o, 1);

      // Mask change mid-window only affects later samples.
      beam_mask_i = 2'b00;
      c = cyc;
      exp_q.push_back(mk_rec(2'b11, 1, c));
      trig_i = 2'b10; tick();
      beam_mask_i = 2'b10; trig_i = 2'b00; tick();
      trig_i = 2'b11; tick();
      trig_i = 2'b00;
      drain();
      beam_mask_i = 2'b00;
      check("midmask_count", event_count_o, 2);

      // Backpressure: five events into a depth-4 FIFO.
      do_reset();
      evt_tready = 1'b0;
      for (int e = 0; e < 5; e++) begin
         b = (e % 2 == 1) ? 2'b10 : 2'b01;
         c = cyc;
         if (e < 4) exp_q.push_back(mk_rec(b, e, c));
         pulse(b);
         repeat (5) tick();
      end
      check("bp_overflow", overflow_o, 1);
      check("bp_count", event_count_o, 4);
      check("bp_tvalid", evt_tvalid, 1);
      repeat (3) tick();
      evt_tready = 1'b1;
      drain();
      check("bp_tvalid_drained", evt_tvalid, 0);
      check("bp_overflow_sticky", overflow_o, 1);

      // Reset mid-GATHER flushes everything asynchronously.
      do_reset();
      evt_tready = 1'b0;
      pulse(2'b01);
      repeat (6) tick();
      check("pre_rst_tvalid", evt_tvalid, 1);
      check("pre_rst_count", event_count_o, 1);
      pulse(2'b10);
      tick();
      reset_i = 1'b1;
      exp_q.delete();
      #1;
      check("async_rst_tvalid", evt_tvalid, 0);
      check("async_rst_count", event_count_o, 0);
      check("async_rst_overflow", overflow_o, 0);
      tick(); tick();
      reset_i    = 1'b0;
      evt_tready = 1'b1;
      repeat (8) tick();
      check("post_rst_tvalid", evt_tvalid, 0);
      c = cyc;
      exp_q.push_back(mk_rec(2'b01, 0, c));
      pulse(2'b01);
      drain();
      check("post_rst_count", event_count_o, 1);

`ifdef L1_TRIG_SCALERS_EN
      // Scalers count raw triggers even when masked, saturate, and clear.
      do_reset();
      beam_mask_i = 2'b11;
      trig_i      = 2'b01;
      repeat (70000) tick();
      trig_i = 2'b00;
      check("scaler0_sat", scaler_o[15:0], 16'hFFFF);
      check("scaler1_zero", scaler_o[31:16], 16'h0000);
      scaler_clr_i = 1'b1;
      tick();
      scaler_clr_i = 1'b0;
      check("scaler0_clr", scaler_o[15:0], 16'h0000);
      check("scaler_no_evt", event_count_o, 0);
      beam_mask_i = 2'b00;
`endif

      repeat (4) tick();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/l1_trigger_event_builder.md
L1_TRIGGER_EVENT_BUILDER -- requirements
Module: l1_trigger_event_builder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter NBEAMS, default 2: number of beam trigger bits; the legal range is 1..32.
REQ-003 Parameter WINDOW, default 4: coincidence window length in aclk cycles; the legal range is 1..16.
REQ-004 Parameter FIFO_DEPTH, default 4: event FIFO depth; it SHALL be a power of 2, at least 2.
REQ-005 Port aclk, input, 1 bit: sole clock.
REQ-006 Port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port trig_i, input, NBEAMS bits: per-beam trigger bits from the L1 trigger stage, sampled every cycle.
REQ-008 Port beam_mask_i, input, NBEAMS bits: a 1 disables that beam; it is quasi-static.
REQ-009 Port holdoff_i, input, 16 bits: dead-time in cycles after each event.
REQ-010 Ports evt_tdata (output, 128 bits), evt_tvalid (output, 1 bit) and evt_tready (input, 1 bit): AXI4S minimal event-record stream.
REQ-011 Port event_count_o, output, 32 bits: number of events accepted into the FIFO.
REQ-012 Port overflow_o, output, 1 bit: sticky flag, set when an event is dropped.

Function
REQ-013 A free-running 48-bit timestamp SHALL count aclk cycles from reset and wrap modulo 2^48.
REQ-014 The FSM SHALL have the states IDLE, GATHER, EMIT and HOLDOFF.
REQ-015 In IDLE, when any bit of (trig_i & ~beam_mask_i) is 1, the FSM SHALL latch those bits into beams_q, latch the timestamp into ts_q, and go to GATHER; when WINDOW=1 it SHALL go directly to EMIT instead.
REQ-016 In GATHER, the FSM SHALL OR (trig_i & ~beam_mask_i) into beams_q for WINDOW-1 cycles, then go to EMIT.
REQ-017 EMIT SHALL last one cycle and push the record; the FSM SHALL then go to HOLDOFF, or to IDLE when holdoff_i=0.
REQ-018 HOLDOFF SHALL last exactly holdoff_i cycles; triggers received during HOLDOFF SHALL be ignored and not latched.
REQ-019 Record layout: [NBEAMS-1:0] = beams_q; [63:32] = event number (the value of event_count_o before the increment); [111:64] = ts_q; all other bits SHALL be 0.
REQ-020 A push in EMIT SHALL be accepted when the FIFO is not full, or when a pop occurs in the same cycle; an accepted push SHALL increment event_count_o (wrapping).
REQ-021 A push in EMIT that is not accepted SHALL drop the record, set overflow_o, and leave event_count_o unchanged.
REQ-022 The FIFO SHALL be first-word-fall-through: evt_tvalid = not empty, evt_tdata = head entry, and the FIFO pops when evt_tvalid & evt_tready.
REQ-023 evt_tdata SHALL be held stable while evt_tvalid=1 and evt_tready=0.
REQ-024 Latency: a trigger sampled in IDLE at cycle 0 SHALL produce evt_tvalid=1 at cycle WINDOW+1 when the FIFO was empty.
REQ-025 Changing beam_mask_i mid-window SHALL affect only the bits sampled after the change.

Reset
REQ-026 On reset_i=1 the FSM SHALL go to IDLE, and the timestamp, the holdoff counter, the FIFO pointers/count, event_count_o and overflow_o SHALL be cleared to 0 immediately (asynchronously).
REQ-027 During reset evt_tvalid SHALL be 0; evt_tdata is don't-care.
REQ-028 A reset asserted mid-window or mid-holdoff SHALL discard the in-flight event.
REQ-029 On reset release the block SHALL restart with the first edge.

Configuration
REQ-030 Macro L1_TRIG_SCALERS_EN, when defined, SHALL add input scaler_clr_i (1 bit) and output scaler_o (NBEAMS x 16 bits).
REQ-031 With L1_TRIG_SCALERS_EN defined, each scaler SHALL count cycles in which its raw trig_i bit is 1, regardless of mask or FSM state, and saturate at 0xFFFF.
REQ-032 With L1_TRIG_SCALERS_EN defined, scaler_clr_i SHALL zero all scalers synchronously; scaler_clr_i SHALL take priority over a simultaneous increment.
REQ-033 With L1_TRIG_SCALERS_EN defined, reset SHALL zero all scalers.
REQ-034 Without L1_TRIG_SCALERS_EN, neither these ports nor the scaler logic SHALL exist.

Structure
REQ-035 Package l1_trig_pkg SHALL hold the FSM state enum, the record field offsets/widths (BEAMS_LSB, EVNUM_LSB=32, TS_LSB=64, TS_W=48), and the record typedef.
REQ-036 The FIFO SHALL be sub-module l1_trig_evt_fifo (parameterised width/depth, FWFT, with full/empty/count outputs).

Verification
REQ-037 With WINDOW=4 and holdoff_i=0, trig_i=2'b01 at cycle 0 and 2'b10 at cycle 2 with tready=1 SHALL produce one record with beams=2'b11, event number 0 and tvalid at cycle 5.
REQ-038 With holdoff_i=10, triggers at cycles 0, 8 and 20 SHALL produce exactly 2 records (cycles 0 and 20), with event_count_o=2.
REQ-039 With beam_mask_i=2'b01 and trig_i=2'b01 pulsed repeatedly, no record SHALL be produced; a following trig_i=2'b10 SHALL produce a record with beams=2'b10.
REQ-040 With evt_tready=0, FIFO_DEPTH=4 and 5 events, 4 records SHALL be held, overflow_o=1 and event_count_o=4; draining SHALL return event numbers 0..3 in order with stable tdata under backpressure.
REQ-041 reset_i asserted during GATHER SHALL produce no record; evt_tvalid=0, event_count_o=0 and overflow_o=0, and the next trigger SHALL yield event number 0.
REQ-042 With L1_TRIG_SCALERS_EN defined, holding trig_i[0]=1 for 70000 cycles SHALL give scaler_o[0]=0xFFFF, and scaler_clr_i SHALL then return it to 0.
